// File: rtl/code_lock_fsm.sv
`default_nettype none
// ============================================================================
// Module      : code_lock_fsm
// Description : Multi-digit access-code lock. Digits arrive one per strobe and
//               are compared on the fly; a full match opens the door for a
//               timed window, MAX_FAIL consecutive misses raise a timed
//               lockout with alarm. All outputs are registered.
//               Optional build macro CODE_LOCK_PROG_EN adds a programmable
//               code register (ports prog_we / prog_code).
// Revision    : 1.0 - initial release
// ============================================================================
module code_lock_fsm #(
   parameter int                       CODE_W         = 4,
   parameter int                       DIGITS         = 4,
   parameter logic [DIGITS*CODE_W-1:0] CODE           = 16'h9371,
   parameter int                       MAX_FAIL       = 3,
   parameter int                       OPEN_CYCLES    = 8,
   parameter int                       LOCKOUT_CYCLES = 16,
   parameter int                       TIMEOUT_CYCLES = 32
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             digit_valid,
   input  logic [CODE_W-1:0]                digit,
   input  logic                             clear,
`ifdef CODE_LOCK_PROG_EN
   input  logic                             prog_we,
   input  logic [DIGITS*CODE_W-1:0]         prog_code,
`endif
   output logic                             open_access_door,
   output logic                             alarm,
   output logic [1:0]                       state_out,
   output logic [$clog2(MAX_FAIL+1)-1:0]    fail_count
);

   // Widths; the digit index needs at least one bit even for a 1-digit code
   localparam int c_idx_w  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int c_fc_w   = $clog2(MAX_FAIL + 1);
   localparam int c_tmax   = (OPEN_CYCLES > LOCKOUT_CYCLES) ?
                             ((OPEN_CYCLES > TIMEOUT_CYCLES) ? OPEN_CYCLES : TIMEOUT_CYCLES) :
                             ((LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES : TIMEOUT_CYCLES);
   localparam int c_tmr_w  = (c_tmax > 1) ? $clog2(c_tmax) : 1;

   // Timers count down from N-1 to zero, so the exit fires on the Nth edge
   localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(DIGITS - 1);
   localparam logic [c_idx_w-1:0] c_idx_one   = c_idx_w'(1);
   localparam logic [c_tmr_w-1:0] c_open_load = c_tmr_w'(OPEN_CYCLES - 1);
   localparam logic [c_tmr_w-1:0] c_lock_load = c_tmr_w'(LOCKOUT_CYCLES - 1);
   localparam logic [c_tmr_w-1:0] c_tmo_load  = c_tmr_w'(TIMEOUT_CYCLES - 1);
   localparam logic [c_fc_w-1:0]  c_fail_last = c_fc_w'(MAX_FAIL - 1);
   localparam logic [c_fc_w-1:0]  c_fail_max  = c_fc_w'(MAX_FAIL);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_ENTRY   = 2'b01,
      S_OPEN    = 2'b10,
      S_LOCKOUT = 2'b11
   } state_t;

   state_t                    r_state;
   logic [c_idx_w-1:0]        r_index;
   logic                      r_mismatch;
   logic [c_tmr_w-1:0]        r_timer;
   logic                      r_door;
   logic                      r_alarm;
   logic [c_fc_w-1:0]         r_fail;

   logic [DIGITS*CODE_W-1:0]  w_code;
   logic [c_idx_w-1:0]        w_idx;
   logic [CODE_W-1:0]         w_exp;
   logic                      w_mismatch;
   logic                      w_last;
   logic                      w_complete;

`ifdef CODE_LOCK_PROG_EN
   logic [DIGITS*CODE_W-1:0]  r_code;

   // Code register: reloadable only while idle with the door shut
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_code <= CODE;
      end else if (prog_we && (r_state == S_IDLE) && !r_door) begin
         r_code <= prog_code;
      end
   end

   assign w_code = r_code;
`else
   assign w_code = CODE;
`endif

   // Expected digit for the current position and running mismatch; the
   // first digit is judged from IDLE, where the position is implicitly 0
   always_comb begin
      w_idx = (r_state == S_ENTRY) ? r_index : '0;
      w_exp = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (w_idx == c_idx_w'(i)) begin
            w_exp = w_code[(DIGITS-1-i)*CODE_W +: CODE_W];
         end
      end
      w_mismatch = ((r_state == S_ENTRY) && r_mismatch) || (digit != w_exp);
      w_last     = (w_idx == c_last_idx);
      w_complete = digit_valid && w_last &&
                   ((r_state == S_IDLE) || ((r_state == S_ENTRY) && !clear));
   end

   // Main lock sequencer with registered door/alarm/fail outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_index    <= '0;
         r_mismatch <= 1'b0;
         r_timer    <= '0;
         r_door     <= 1'b0;
         r_alarm    <= 1'b0;
         r_fail     <= '0;
      end else if (w_complete) begin
         r_index    <= '0;
         r_mismatch <= 1'b0;
         if (!w_mismatch) begin
            r_state <= S_OPEN;
            r_door  <= 1'b1;
            r_fail  <= '0;
            r_timer <= c_open_load;
         end else if (r_fail == c_fail_last) begin
            r_state <= S_LOCKOUT;
            r_alarm <= 1'b1;
            r_fail  <= c_fail_max;
            r_timer <= c_lock_load;
         end else begin
            r_state <= S_IDLE;
            r_fail  <= r_fail + c_fc_w'(1);
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (digit_valid) begin
                  r_state    <= S_ENTRY;
                  r_index    <= c_idx_one;
                  r_mismatch <= w_mismatch;
                  r_timer    <= c_tmo_load;
               end
            end
            S_ENTRY: begin
               if (clear) begin
                  r_state    <= S_IDLE;
                  r_index    <= '0;
                  r_mismatch <= 1'b0;
               end else if (digit_valid) begin
                  r_index    <= r_index + c_idx_one;
                  r_mismatch <= w_mismatch;
                  r_timer    <= c_tmo_load;
               end else if (r_timer == '0) begin
                  r_state    <= S_IDLE;
                  r_index    <= '0;
                  r_mismatch <= 1'b0;
               end else begin
                  r_timer <= r_timer - c_tmr_w'(1);
               end
            end
            S_OPEN: begin
               if (r_timer == '0) begin
                  r_state <= S_IDLE;
                  r_door  <= 1'b0;
               end else begin
                  r_timer <= r_timer - c_tmr_w'(1);
               end
            end
            default: begin
               if (r_timer == '0) begin
                  r_state <= S_IDLE;
                  r_alarm <= 1'b0;
                  r_fail  <= '0;
               end else begin
                  r_timer <= r_timer - c_tmr_w'(1);
               end
            end
         endcase
      end
   end

   assign open_access_door = r_door;
   assign alarm            = r_alarm;
   assign state_out        = r_state;
   assign fail_count       = r_fail;

endmodule
`default_nettype wire
